// File: rtl/clk_tick_timer.sv
// clk_tick_timer
// Samples a divided clock (tick_clk_in) as plain data in the clk_in domain,
// emits a one-cycle tick per rising edge, and drives a loadable down-counter
// timer (one-shot or periodic) from those ticks. Nothing is clocked off the
// divided clock.
// Optional build macro: CLK_TICK_SYNC_EN adds a two-flop synchronizer ahead of
// the edge detector so tick_clk_in may be asynchronous to clk_in (+2 cycles
// of tick latency).
module clk_tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_clk_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick,
  output logic             expired
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_expired;
  logic             r_t0;
  logic             r_t1;
  logic             w_tick_src;
  logic             w_tick;

`ifdef CLK_TICK_SYNC_EN
  logic r_s0;
  logic r_s1;

  // Two-flop synchronizer; resets high so an input held high gives no tick.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      r_s0 <= tick_clk_in;
      r_s1 <= r_s0;
    end
  end

  assign w_tick_src = r_s1;
`else
  // Divided clock comes from the same clk_in domain, so sample it directly.
  assign w_tick_src = tick_clk_in;
`endif

  // Edge-detect history; both reset high so no spurious tick out of reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_t0 <= 1'b1;
      r_t1 <= 1'b1;
    end else begin
      r_t0 <= w_tick_src;
      r_t1 <= r_t0;
    end
  end

  assign w_tick = r_t0 & ~r_t1;

  // Timer FSM; per-cycle priority is stop, load, start, tick.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // stop in IDLE simply holds; ticks are ignored while idle.
          if (!stop) begin
            if (load) begin
              r_count  <= load_val;
              r_reload <= load_val;
            end else if (start && (r_count != '0)) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            // count holds so a later start resumes where we left off
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end else if (load) begin
            // restart with the new value; any coincident tick is dropped
            r_count  <= load_val;
            r_reload <= load_val;
            if (load_val == '0) begin
              r_state   <= S_IDLE;
              r_running <= 1'b0;
            end
          end else if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
              r_count <= r_count - WIDTH'(1);
            end else begin
              r_expired <= 1'b1;
              if (periodic) begin
                // reload directly so count never shows 0 in periodic mode
                r_count <= r_reload;
              end else begin
                r_count   <= '0;
                r_state   <= S_IDLE;
                r_running <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign tick    = w_tick;
  assign expired = r_expired;

endmodule
